// File: rtl/rca_pkg.sv
// Shared definitions for the ripple-carry adder datapath: sequencer state
// encodings and the nibble width used by the serial adder.
package rca_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fulladder_4bit.sv
// 4-bit ripple-carry adder built from a chain of single-bit full adders.
module fulladder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry_chain;

    assign carry_chain[0] = cin;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bit
            assign sum[gi]           = a[gi] ^ b[gi] ^ carry_chain[gi];
            assign carry_chain[gi+1] = (a[gi] & b[gi]) | (carry_chain[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry_chain[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit adder: one shared 4-bit adder processes one nibble per
// cycle, LSB first, with the carry held in a register between nibbles.
module nibble_serial_adder_ctrl
    import rca_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               carry_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic               cout_reg;

    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] fa_sum;
    logic                fa_cout;

    // Nibble mux: select the operand slice addressed by the pass counter.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt_reg == CNT_W'(i)) begin
                a_nib = a_reg[i*NIBBLE_W +: NIBBLE_W];
                b_nib = b_reg[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    fulladder_4bit u_fulladder_4bit (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_reg),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        cnt_reg   <= '0;
                        sum_reg   <= '0;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (cnt_reg == CNT_W'(i)) begin
                            sum_reg[i*NIBBLE_W +: NIBBLE_W] <= fa_sum;
                        end
                    end
                    carry_reg <= fa_cout;
                    // Counter parks on the last nibble; it is cleared on the next accept.
                    if (cnt_reg == CNT_LAST) begin
                        cout_reg  <= fa_cout;
                        state_reg <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign busy      = (state_reg == ST_RUN) || (state_reg == ST_DONE);
    assign sum       = sum_reg;
    assign cout      = cout_reg;

endmodule
